seg_display_scanner: RTL and testbench

Consumer end of the stopwatch clock divider. Takes the divided 400 Hz refresh and 2 Hz blink level signals, plus four BCD digits from the stopwatch counter. Time-multiplexes the digits onto a 4-anode, 7-segment display. In adjust mode it blanks the selected digits at the blink rate.

---
 rtl/stopwatch_pkg.sv | 54 +++++
 rtl/level_sync_edge.sv | 27 ++
 rtl/seg_display_scanner.sv | 80 ++++++++
 tb/tb_seg_display_scanner.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch display constants: digit count, 7-segment patterns and decoder.
// HEX_DECODE_EN: when defined, codes 10..15 decode to A,b,C,d,E,F instead of blank.
package stopwatch_pkg;

    localparam int NUM_DIGITS = 4;

    // Patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the output stage.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef logic [1:0] digit_idx_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
`ifdef HEX_DECODE_EN
            4'd10:   pat = SEG_A;
            4'd11:   pat = SEG_B;
            4'd12:   pat = SEG_C;
            4'd13:   pat = SEG_D;
            4'd14:   pat = SEG_E;
            4'd15:   pat = SEG_F;
`endif
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/level_sync_edge.sv
// Two-flop synchronizer for a slow divided level, plus a one-cycle rising-edge pulse.
module level_sync_edge (
    input  logic sclk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic r1, r2, r3;

    always_ff @(posedge sclk) begin
        if (rst) begin
            r1 <= 1'b0;
            r2 <= 1'b0;
            r3 <= 1'b0;
        end else begin
            r1 <= async_in;
            r2 <= r1;
            r3 <= r2;
        end
    end

    assign level = r2;
    assign rise  = r2 & ~r3;

endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexes four BCD digits onto a 4-anode 7-segment display, blanking masked digits at the blink rate.
// HEX_DECODE_EN (see stopwatch_pkg) enables A..F glyphs for codes 10..15.
module seg_display_scanner
    import stopwatch_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    sclk,
    input  logic                    rst,
    input  logic                    clk_400hz,
    input  logic                    clk_2hz,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    logic       scan_tick, unused_scan_level;
    logic       blink_on, unused_blink_rise;
    digit_idx_t idx;

    level_sync_edge u_scan_sync (
        .sclk     (sclk),
        .rst      (rst),
        .async_in (clk_400hz),
        .level    (unused_scan_level),
        .rise     (scan_tick)
    );

    level_sync_edge u_blink_sync (
        .sclk     (sclk),
        .rst      (rst),
        .async_in (clk_2hz),
        .level    (blink_on),
        .rise     (unused_blink_rise)
    );

    always_ff @(posedge sclk) begin
        if (rst)
            idx <= '0;
        else if (scan_tick)
            idx <= idx + 2'd1;
    end

    logic                  blanked;
    logic [NUM_DIGITS-1:0] an_hot;
    logic [6:0]            seg_hot;
    logic                  dp_hot;

    // Active-high view of the current digit; an all-zero view means "everything off".
    always_comb begin
        blanked     = blink_mask[idx] & blink_on;
        an_hot      = '0;
        an_hot[idx] = 1'b1;
        seg_hot     = seg_decode(digits[4*idx +: 4]);
        dp_hot      = dp_mask[idx];
        if (blanked) begin
            an_hot  = '0;
            seg_hot = SEG_BLANK;
            dp_hot  = 1'b0;
        end
    end

    // Reloaded every cycle so input changes show up one cycle later regardless of the scan tick.
    always_ff @(posedge sclk) begin
        if (rst) begin
            an  <= {NUM_DIGITS{ACTIVE_LOW}};
            seg <= {7{ACTIVE_LOW}};
            dp  <= ACTIVE_LOW;
        end else begin
            an  <= an_hot  ^ {NUM_DIGITS{ACTIVE_LOW}};
            seg <= seg_hot ^ {7{ACTIVE_LOW}};
            dp  <= dp_hot  ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench: stimulus queues expected {an,seg,dp} per cycle, a negedge monitor pops and compares.
module tb_seg_display_scanner;

    logic        sclk = 1'b0;
    logic        rst;
    logic        clk_400hz, clk_2hz;
    logic [15:0] digits;
    logic [3:0]  blink_mask, dp_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    seg_display_scanner #(.ACTIVE_LOW(1'b1), .NUM_DIGITS(4)) dut (
        .sclk       (sclk),
        .rst        (rst),
        .clk_400hz  (clk_400hz),
        .clk_2hz    (clk_2hz),
        .digits     (digits),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 sclk = ~sclk;

`ifdef HEX_DECODE_EN
    localparam logic [6:0] EXP_A = 7'h08;
    localparam logic [6:0] EXP_F = 7'h0E;
`else
    localparam logic [6:0] EXP_A = 7'h7F;
    localparam logic [6:0] EXP_F = 7'h7F;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge sclk) cyc <= cyc + 1;

    always @(negedge sclk) begin
        checks++;
        if ($countones(~an) > 1) begin
            failures++;
            $display("FAIL onehot cyc=%0d an=%b (at most one active anode required)", cyc, an);
        end
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            checks++;
            if (mon_e.cyc < cyc) begin
                failures++;
                $display("FAIL %s missed check at cyc=%0d", mon_e.name, mon_e.cyc);
            end else if (an !== mon_e.an || seg !== mon_e.seg || dp !== mon_e.dp) begin
                failures++;
                $display("FAIL %s cyc=%0d got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
                         mon_e.name, cyc, an, seg, dp, mon_e.an, mon_e.seg, mon_e.dp);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge sclk);
        #2;
    endtask

    task automatic expect_at(input int off, input logic [3:0] a, input logic [6:0] s,
                             input logic d, input string nm);
        exp_t e;
        e.cyc = cyc + off; e.an = a; e.seg = s; e.dp = d; e.name = nm;
        q.push_back(e);
    endtask

    // One clk_400hz rising edge: old view through E2, new view from E3, held-high must not re-advance.
    task automatic pulse(input logic [3:0] oa, input logic [6:0] os, input logic od,
                         input logic [3:0] na, input logic [6:0] ns, input logic nd,
                         input int hold, input string nm);
        clk_400hz = 1'b1;
        expect_at(3, oa, os, od, {nm, "_before"});
        expect_at(4, na, ns, nd, {nm, "_after"});
        step(hold);
        clk_400hz = 1'b0;
        expect_at(3, na, ns, nd, {nm, "_hold"});
        step(4);
    endtask

    initial begin
        rst = 1'b1; clk_400hz = 1'b0; clk_2hz = 1'b0;
        digits = 16'h1234; blink_mask = 4'b0000; dp_mask = 4'b0000;

        for (int i = 1; i <= 3; i++) expect_at(i, 4'hF, 7'h7F, 1'b1, "reset");
        step(3);
        rst = 1'b0;
        expect_at(1, 4'hE, 7'h19, 1'b1, "post_reset_idx0");
        expect_at(2, 4'hE, 7'h19, 1'b1, "idle_idx0");
        step(4);

        // digits 1234: idx0='4', idx1='3', idx2='2', idx3='1'
        pulse(4'hE, 7'h19, 1'b1, 4'hD, 7'h30, 1'b1, 6,  "scan_0to1");
        pulse(4'hD, 7'h30, 1'b1, 4'hB, 7'h24, 1'b1, 6,  "scan_1to2");
        pulse(4'hB, 7'h24, 1'b1, 4'h7, 7'h79, 1'b1, 12, "scan_2to3_longhigh");
        pulse(4'h7, 7'h79, 1'b1, 4'hE, 7'h19, 1'b1, 6,  "scan_wrap_3to0");

        // Blink digit 0
        blink_mask = 4'b0001;
        clk_2hz = 1'b1;
        expect_at(2, 4'hE, 7'h19, 1'b1, "blink_sync_lag");
        expect_at(3, 4'hF, 7'h7F, 1'b1, "blink_blank");
        step(6);
        clk_2hz = 1'b0;
        expect_at(2, 4'hF, 7'h7F, 1'b1, "unblink_lag");
        expect_at(3, 4'hE, 7'h19, 1'b1, "unblink_show");
        step(4);
        clk_2hz = 1'b1;
        step(4);
        pulse(4'hF, 7'h7F, 1'b1, 4'hD, 7'h30, 1'b1, 6, "blink_other_digit");
        clk_2hz = 1'b0; blink_mask = 4'b0000;
        step(4);

        // Decode range and dp: FA90 -> idx0='0', idx1='9', idx2=A, idx3=F
        digits = 16'hFA90; dp_mask = 4'b0100;
        expect_at(1, 4'hD, 7'h10, 1'b1, "digits_change_idx1");
        step(2);
        pulse(4'hD, 7'h10, 1'b1, 4'hB, EXP_A, 1'b0, 6, "decode_A_dp");
        pulse(4'hB, EXP_A, 1'b0, 4'h7, EXP_F, 1'b1, 6, "decode_F");
        pulse(4'h7, EXP_F, 1'b1, 4'hE, 7'h40, 1'b1, 6, "decode_0");
        pulse(4'hE, 7'h40, 1'b1, 4'hD, 7'h10, 1'b1, 6, "to_idx1");
        pulse(4'hD, 7'h10, 1'b1, 4'hB, EXP_A, 1'b0, 6, "to_idx2");

        // Reset with a tick in flight at idx2
        clk_400hz = 1'b1;
        step(2);
        rst = 1'b1; clk_400hz = 1'b0;
        expect_at(1, 4'hF, 7'h7F, 1'b1, "midreset_inactive");
        step(1);
        rst = 1'b0;
        expect_at(1, 4'hE, 7'h40, 1'b1, "midreset_idx0");
        expect_at(6, 4'hE, 7'h40, 1'b1, "midreset_no_advance");
        step(8);

        for (int i = 0; i < 20 && q.size() != 0; i++) step(1);
        while (q.size() != 0) begin
            mon_e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s timeout, check at cyc=%0d never reached", mon_e.name, mon_e.cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
